// File: rtl/frame_sched_pkg.sv
// Shared types and defaults for the frame slot scheduler and the marker/data framer.
package frame_sched_pkg;

  typedef enum logic [1:0] {
    SELECT = 2'd0,
    DATA   = 2'd1,
    FILL   = 2'd2
  } sched_state_e;

  localparam int         SCHED_FRAME_BITS   = 2816;
  localparam int         SCHED_SLOT_BITS    = 8;
  localparam logic [7:0] SCHED_FILL_PATTERN = 8'b10101010;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/frame_slot_counter.sv
// Bit-in-slot, bit-in-frame and slot-in-frame counters; the frame wrap forces slot 0.
module frame_slot_counter
  import frame_sched_pkg::*;
#(
  parameter  int SLOT_BITS  = SCHED_SLOT_BITS,
  parameter  int FRAME_BITS = SCHED_FRAME_BITS,
  localparam int BIT_W      = clog2(SLOT_BITS),
  localparam int FRM_W      = clog2(FRAME_BITS),
  localparam int SLOT_W     = clog2(FRAME_BITS / SLOT_BITS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              slot_start_i,
  input  logic              advance_i,
  output logic [BIT_W-1:0]  bit_cnt_o,
  output logic [SLOT_W-1:0] slot_idx_o,
  output logic              slot_end_o,
  output logic              frame_end_o
);

  logic [BIT_W-1:0]  bit_cnt_q,   bit_cnt_d;
  logic [FRM_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [SLOT_W-1:0] slot_idx_q,  slot_idx_d;

  assign slot_end_o  = advance_i && (bit_cnt_q == BIT_W'(SLOT_BITS - 1));
  assign frame_end_o = advance_i && (frame_cnt_q == FRM_W'(FRAME_BITS - 1));
  assign bit_cnt_o   = bit_cnt_q;
  assign slot_idx_o  = slot_idx_q;

  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no path can infer a latch.
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    slot_idx_d  = slot_idx_q;
    if (slot_start_i) begin
      bit_cnt_d = '0;
    end
    if (advance_i) begin
      bit_cnt_d   = slot_end_o  ? '0 : bit_cnt_q + 1'b1;
      frame_cnt_d = frame_end_o ? '0 : frame_cnt_q + 1'b1;
      if (frame_end_o) begin
        slot_idx_d = '0;
      end else if (slot_end_o) begin
        slot_idx_d = slot_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
    if (!reset) begin
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
      slot_idx_q  <= '0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      slot_idx_q  <= slot_idx_d;
    end
  end

endmodule

// File: rtl/frame_slot_scheduler.sv
// Round-robin TDM scheduler feeding the framer's FIFO-style input from NCH channel FIFOs.
// Optional fill-slot statistics output enabled by defining FRAME_SLOT_FILL_STATS_EN.
module frame_slot_scheduler
  import frame_sched_pkg::*;
#(
  parameter  int                   NCH          = 4,
  parameter  int                   SLOT_BITS    = SCHED_SLOT_BITS,
  parameter  int                   FRAME_BITS   = SCHED_FRAME_BITS,
  parameter  logic [SLOT_BITS-1:0] FILL_PATTERN = SLOT_BITS'(SCHED_FILL_PATTERN),
  localparam int                   CH_W         = clog2(NCH),
  localparam int                   FILL_W       = clog2(FRAME_BITS / SLOT_BITS) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NCH-1:0]  ch_en,
  input  logic [NCH-1:0]  ch_emp,
  input  logic [NCH-1:0]  ch_dat,
  output logic [NCH-1:0]  ch_rack,
  output logic            fr_emp,
  output logic            fr_dat,
  input  logic            fr_rack,
  output logic [CH_W-1:0] cur_ch,
  output logic            cur_fill,
  output logic            err
`ifdef FRAME_SLOT_FILL_STATS_EN
  ,
  output logic [FILL_W-1:0] fill_cnt
`endif
);

  localparam int BIT_W  = clog2(SLOT_BITS);
  localparam int SLOT_W = clog2(FRAME_BITS / SLOT_BITS);

  if ((FRAME_BITS % SLOT_BITS) != 0 || NCH < 2 || NCH > 8) begin : g_bad_params
    $error("frame_slot_scheduler: FRAME_BITS must be a multiple of SLOT_BITS and NCH in 2..8");
  end

  sched_state_e      state_q, state_d;
  logic [CH_W-1:0]   cur_ch_q;
  logic              cur_fill_q, err_q;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BIT_W-1:0]  fill_idx;
  logic [SLOT_W-1:0] slot_idx, sel_wide;
  logic [CH_W-1:0]   sel;
  logic              slot_end, frame_end, advance, go_data, in_select;

  assign sel_wide  = slot_idx % SLOT_W'(NCH);
  assign sel       = sel_wide[CH_W-1:0];
  assign go_data   = ch_en[sel] && !ch_emp[sel];
  assign in_select = (state_q == SELECT);
  assign advance   = fr_rack && !fr_emp;
  assign fill_idx  = BIT_W'(SLOT_BITS - 1) - bit_cnt;

  frame_slot_counter #(
    .SLOT_BITS  (SLOT_BITS),
    .FRAME_BITS (FRAME_BITS)
  ) u_counter (
    .clk          (clk),
    .reset        (reset),
    .slot_start_i (in_select),
    .advance_i    (advance),
    .bit_cnt_o    (bit_cnt),
    .slot_idx_o   (slot_idx),
    .slot_end_o   (slot_end),
    .frame_end_o  (frame_end)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= SELECT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SELECT:     state_d = go_data ? DATA : FILL;
      DATA, FILL: if (slot_end) state_d = SELECT;
      default:    state_d = SELECT;
    endcase
  end

  // Once a slot starts it stays data or fill; a drained channel simply stalls the framer.
  always_comb begin
    fr_emp  = 1'b1;
    fr_dat  = 1'b0;
    ch_rack = '0;
    case (state_q)
      DATA: begin
        fr_emp            = ch_emp[cur_ch_q];
        fr_dat            = ch_dat[cur_ch_q];
        ch_rack[cur_ch_q] = fr_rack;
      end
      FILL: begin
        fr_emp = 1'b0;
        fr_dat = FILL_PATTERN[fill_idx];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_ch_q   <= '0;
      cur_fill_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (in_select) begin
        cur_ch_q   <= sel;
        cur_fill_q <= !go_data;
      end
      if (fr_rack && fr_emp) err_q <= 1'b1;
    end
  end

  assign cur_ch   = cur_ch_q;
  assign cur_fill = cur_fill_q;
  assign err      = err_q;

`ifdef FRAME_SLOT_FILL_STATS_EN
  logic [FILL_W-1:0] fill_acc_q, fill_cnt_q;

  // The final slot's fill was counted at its SELECT, before the frame-boundary rack.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fill_acc_q <= '0;
      fill_cnt_q <= '0;
    end else if (frame_end) begin
      fill_cnt_q <= fill_acc_q;
      fill_acc_q <= '0;
    end else if (in_select && !go_data) begin
      fill_acc_q <= fill_acc_q + 1'b1;
    end
  end

  assign fill_cnt = fill_cnt_q;
`endif

endmodule

// File: tb/tb_frame_slot_scheduler.sv
// Randomized bench: channel FIFOs as queues, a 3-cycle framer, and a frame-position reference model.
module tb_frame_slot_scheduler;

  localparam int         NCH        = 4;
  localparam int         SLOT_BITS  = 8;
  localparam int         FRAME_BITS = 2816;
  localparam int         SLOTS      = FRAME_BITS / SLOT_BITS;
  localparam logic [7:0] FILL       = 8'b10101010;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [NCH-1:0] ch_en = '1;
  logic [NCH-1:0] ch_emp = '1;
  logic [NCH-1:0] ch_dat = '0;
  logic [NCH-1:0] ch_rack;
  logic           fr_emp, fr_dat;
  logic           fr_rack = 1'b0;
  logic [1:0]     cur_ch;
  logic           cur_fill, err;
`ifdef FRAME_SLOT_FILL_STATS_EN
  logic [9:0]     fill_cnt;
`endif

  frame_slot_scheduler dut (
    .clk      (clk),
    .reset    (reset),
    .ch_en    (ch_en),
    .ch_emp   (ch_emp),
    .ch_dat   (ch_dat),
    .ch_rack  (ch_rack),
    .fr_emp   (fr_emp),
    .fr_dat   (fr_dat),
    .fr_rack  (fr_rack),
    .cur_ch   (cur_ch),
    .cur_fill (cur_fill),
    .err      (err)
`ifdef FRAME_SLOT_FILL_STATS_EN
    ,
    .fill_cnt (fill_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  bit             chq[NCH][$];
  logic [NCH-1:0] pop_mask = '0;
  logic [NCH-1:0] refill_mask = '1;
  int             rack_obs[NCH];
  int             frame_bit, slot_ch, gap, bits_done, bubbles, first_ch, stall_cnt;
  bit             slot_fill, pending, bad_arm, stall_hook;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (frame bit %0d)", tag, got, exp, frame_bit);
    end
  endtask

  task automatic drive_ch();
    for (int c = 0; c < NCH; c++) begin
      ch_emp[c] = (chq[c].size() == 0);
      ch_dat[c] = (chq[c].size() == 0) ? 1'b0 : chq[c][0];
    end
  endtask

  task automatic apply_pops();
    for (int c = 0; c < NCH; c++)
      if (pop_mask[c] && chq[c].size() > 0) void'(chq[c].pop_front());
    pop_mask = '0;
  endtask

  task automatic clear_obs();
    bubbles = 0;
    for (int c = 0; c < NCH; c++) rack_obs[c] = 0;
  endtask

  // One clock: update FIFOs, let the framer act, compare against the frame-position model.
  task automatic step();
    int bitpos;
    logic exp_dat;
    @(negedge clk);
    apply_pops();
    for (int c = 0; c < NCH; c++)
      if (refill_mask[c] && chq[c].size() < 16)
        repeat (32) chq[c].push_back(1'($urandom));
    if (stall_hook && chq[0].size() == 0) begin
      stall_cnt++;
      if (stall_cnt >= 20) begin
        repeat (13) chq[0].push_back(1'($urandom));
        stall_hook = 1'b0;
      end
    end
    drive_ch();
    fr_rack = 1'b0;
    #1;
    gap++;
    if (fr_emp) bubbles++;
    if (pending) begin
      check("select_emp", fr_emp, 1);
      slot_ch   = (frame_bit / SLOT_BITS) % NCH;
      slot_fill = !ch_en[slot_ch] || (chq[slot_ch].size() == 0);
      pending   = 1'b0;
      if (bad_arm) begin
        fr_rack = 1'b1;
        bad_arm = 1'b0;
        #1;
        check("select_rack_chrack", ch_rack, 0);
      end
    end else if (!fr_emp && gap >= 3) begin
      bitpos  = frame_bit % SLOT_BITS;
      exp_dat = slot_fill ? FILL[SLOT_BITS-1-bitpos]
                          : ((chq[slot_ch].size() > 0) ? chq[slot_ch][0] : 1'b0);
      check("fr_dat", fr_dat, exp_dat);
      check("cur_ch", cur_ch, slot_ch);
      check("cur_fill", cur_fill, slot_fill);
      if (frame_bit == 0) first_ch = cur_ch;
      fr_rack = 1'b1;
      #1;
      check("ch_rack", ch_rack, slot_fill ? 0 : (1 << slot_ch));
      gap = 0;
      bits_done++;
      frame_bit = (frame_bit + 1) % FRAME_BITS;
      if (frame_bit % SLOT_BITS == 0) pending = 1'b1;
    end else begin
      if (stall_hook && chq[0].size() == 0) check("stall_emp", fr_emp, 1);
      check("idle_chrack", ch_rack, 0);
    end
    for (int c = 0; c < NCH; c++)
      if (ch_rack[c]) begin
        rack_obs[c]++;
        pop_mask[c] = 1'b1;
      end
  endtask

  task automatic run_bits(input int n);
    int start, cyc;
    start = bits_done;
    cyc   = 0;
    while (bits_done - start < n && cyc < n * 6 + 100) begin
      step();
      cyc++;
    end
    check("bits_delivered", bits_done - start, n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    apply_pops();
    reset   = 1'b0;
    fr_rack = 1'b0;
    drive_ch();
    @(posedge clk);
    #1;
    check("rst_fr_emp", fr_emp, 1);
    check("rst_fr_dat", fr_dat, 0);
    check("rst_ch_rack", ch_rack, 0);
    check("rst_cur_ch", cur_ch, 0);
    check("rst_cur_fill", cur_fill, 0);
    check("rst_err", err, 0);
`ifdef FRAME_SLOT_FILL_STATS_EN
    check("rst_fill_cnt", fill_cnt, 0);
`endif
    reset     = 1'b1;
    frame_bit = 0;
    pending   = 1'b1;
    gap       = 3;
  endtask

  initial begin
    int lvl;
    bits_done  = 0;
    bad_arm    = 1'b0;
    stall_hook = 1'b0;
    stall_cnt  = 0;
    for (int c = 0; c < NCH; c++) repeat (64) chq[c].push_back(1'($urandom));

    // All channels live: round-robin order, slot count and per-channel share per frame.
    do_reset();
    clear_obs();
    run_bits(FRAME_BITS);
    check("slots_per_frame", bubbles, SLOTS);
    for (int c = 0; c < NCH; c++) check($sformatf("racks_ch%0d", c), rack_obs[c], FRAME_BITS / NCH);
    first_ch = 99;
    run_bits(64);
    check("frame2_slot0_ch", first_ch, 0);

    // Channel 2 permanently empty: its slots are fill and it is never acked.
    chq[2].delete();
    refill_mask = 4'b1011;
    do_reset();
    clear_obs();
    run_bits(FRAME_BITS);
    check("ch2_no_rack", rack_obs[2], 0);
    step();
`ifdef FRAME_SLOT_FILL_STATS_EN
    check("fill_cnt_frame1", fill_cnt, SLOTS / NCH);
`endif

    // Channel 1 disabled with data waiting: fill slots, FIFO untouched.
    refill_mask = '1;
    ch_en       = 4'b1101;
    do_reset();
    lvl = chq[1].size();
    run_bits(40 * SLOT_BITS);
    check("ch1_level", chq[1].size(), lvl);
    ch_en = '1;

    // Channel 0 drains after 3 bits of its slot, refills after ~20 cycles.
    do_reset();
    chq[0].delete();
    repeat (3) chq[0].push_back(1'($urandom));
    refill_mask = 4'b1110;
    stall_cnt   = 0;
    stall_hook  = 1'b1;
    run_bits(2 * SLOT_BITS);
    refill_mask = '1;
    run_bits(2 * SLOT_BITS);

    // Rack during SELECT: sticky error, stream unaffected.
    do_reset();
    run_bits(10);
    check("err_before", err, 0);
    bad_arm = 1'b1;
    run_bits(14);
    check("err_set", err, 1);
    run_bits(24);
    check("err_sticky", err, 1);

    // Reset mid-slot: clears err and restarts at slot 0 / channel 0.
    do_reset();
    run_bits(13 * SLOT_BITS + 3);
    do_reset();
    first_ch = 99;
    run_bits(2 * SLOT_BITS);
    check("post_reset_ch0", first_ch, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
